// File: rtl/apb_wb_arbiter_if.sv
// Bundle of the two-requester request/response side and the APB master side
// of the arbiter. The master modport is the arbiter's view of the bundle.
interface apb_wb_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]            req;
    logic [1:0]            req_write;
    logic [1:0]            req_prot;
    logic [2*ADDR_W-1:0]   req_addr;
    logic [2*DATA_W-1:0]   req_wdata;
    logic [2*DATA_W/8-1:0] req_strb;
    logic [1:0]            done;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_W-1:0]     PADDR;
    logic                  PPROT;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W/8-1:0]   PSTRB;
    logic                  PREADY;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PSLVERR;

    modport master (
        input  req, req_write, req_prot, req_addr, req_wdata, req_strb,
        output done, rsp_rdata, rsp_err,
        output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output req, req_write, req_prot, req_addr, req_wdata, req_strb,
        input  done, rsp_rdata, rsp_err,
        input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_wb_arbiter.sv
// Round-robin arbiter granting one of two requesters onto a single APB
// master port, with optional ACCESS-phase timeout; all outputs registered.
module apb_wb_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    apb_wb_arbiter_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pprot_q, pprot_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [1:0]          done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                to_hit;

    // Abort fires on the ACCESS cycle that would bring the count up to TIMEOUT.
    assign to_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pprot_d   = pprot_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        done_d    = 2'b00;
        rdata_d   = rdata_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                if (|bus.req) begin
                    // gnt_q doubles as last_grant: on contention pick the other one.
                    gnt_d    = (bus.req == 2'b11) ? ~gnt_q : bus.req[1];
                    paddr_d  = gnt_d ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
                    pwdata_d = gnt_d ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
                    pstrb_d  = gnt_d ? bus.req_strb[2*STRB_W-1:STRB_W]  : bus.req_strb[STRB_W-1:0];
                    pwrite_d = gnt_d ? bus.req_write[1] : bus.req_write[0];
                    pprot_d  = gnt_d ? bus.req_prot[1]  : bus.req_prot[0];
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    err_d     = bus.PSLVERR;
                    done_d    = gnt_q ? 2'b10 : 2'b01;
                    state_d   = DONE;
                end else begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (to_hit) begin
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        rdata_d   = '0;
                        err_d     = 1'b1;
                        done_d    = gnt_q ? 2'b10 : 2'b01;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b1;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pprot_q   <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            done_q    <= 2'b00;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pprot_q   <= pprot_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign bus.PADDR     = paddr_q;
    assign bus.PPROT     = pprot_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.done      = done_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_apb_wb_arbiter.sv
// Directed bench for apb_wb_arbiter: table of single transfers plus
// hand-written timeout and mid-transfer reset sequences.
module tb_apb_wb_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    apb_wb_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_wb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [1:0]  prot;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [3:0]  waits;
        logic [31:0] prdata;
        logic        slverr;
        logic        gnt;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(
        input logic [1:0] req, input logic [1:0] wr, input logic [1:0] prot,
        input logic [31:0] a0, input logic [31:0] a1,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] waits,
        input logic [31:0] prdata, input logic slverr, input logic gnt,
        input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.req = req; v.wr = wr; v.prot = prot; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.s0 = s0; v.s1 = s1; v.waits = waits;
        v.prdata = prdata; v.slverr = slverr; v.gnt = gnt;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_req(input vec_t v);
        bus.req_write = v.wr;
        bus.req_prot  = v.prot;
        bus.req_addr  = {v.a1, v.a0};
        bus.req_wdata = {v.d1, v.d0};
        bus.req_strb  = {v.s1, v.s0};
        bus.req       = v.req;
    endtask

    // Called at a negedge with the DUT in IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] ea;
        ea = v.gnt ? v.a1 : v.a0;
        drive_req(v);
        bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
        @(negedge clk);
        chk({tag, ".setup_psel"},    bus.PSEL, 1'b1);
        chk({tag, ".setup_penable"}, bus.PENABLE, 1'b0);
        chk({tag, ".paddr"},         bus.PADDR, ea);
        chk({tag, ".pwrite"},        bus.PWRITE, v.wr[v.gnt]);
        chk({tag, ".pprot"},         bus.PPROT, v.prot[v.gnt]);
        chk({tag, ".pwdata"},        bus.PWDATA, v.gnt ? v.d1 : v.d0);
        chk({tag, ".pstrb"},         bus.PSTRB, v.gnt ? v.s1 : v.s0);
        @(negedge clk);
        chk({tag, ".access_psel"},    bus.PSEL, 1'b1);
        chk({tag, ".access_penable"}, bus.PENABLE, 1'b1);
        for (int w = 0; w < int'(v.waits); w++) begin
            @(negedge clk);
            chk({tag, ".wait_penable"}, bus.PENABLE, 1'b1);
            chk({tag, ".wait_done"},    bus.done, 2'b00);
        end
        bus.PREADY = 1'b1; bus.PRDATA = v.prdata; bus.PSLVERR = v.slverr;
        @(negedge clk);
        chk({tag, ".done"},       bus.done, v.gnt ? 2'b10 : 2'b01);
        chk({tag, ".rdata"},      bus.rsp_rdata, v.exp_rdata);
        chk({tag, ".err"},        bus.rsp_err, v.exp_err);
        chk({tag, ".done_psel"},  {bus.PSEL, bus.PENABLE}, 2'b00);
        bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
        @(negedge clk);
        chk({tag, ".idle_done"},  bus.done, 2'b00);
        chk({tag, ".idle_rsp"},   {bus.rsp_err, bus.rsp_rdata}, 33'd0);
        chk({tag, ".idle_hold"},  bus.PADDR, ea);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_en;
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0;
        bus.req = '0; bus.req_write = '0; bus.req_prot = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_strb = '0;
        bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;

        //            req    wr     prot   a0        a1        d0            d1            s0    s1    w  prdata        e  g  exp_rdata     exp_err
        vecs[0] = mk(2'b11, 2'b00, 2'b01, 32'h100, 32'h200, 32'h11111111, 32'h22222222, 4'h3, 4'hC, 0, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 0);
        vecs[1] = mk(2'b11, 2'b11, 2'b10, 32'h104, 32'h204, 32'h33333333, 32'h44444444, 4'hF, 4'h5, 1, 32'hFFFFFFFF, 0, 1, 32'h0,        0);
        vecs[2] = mk(2'b11, 2'b10, 2'b00, 32'h108, 32'h208, 32'h55555555, 32'h66666666, 4'h1, 4'h2, 0, 32'h87654321, 1, 0, 32'h87654321, 1);
        vecs[3] = mk(2'b10, 2'b00, 2'b10, 32'h0,   32'h300, 32'h0,        32'h77777777, 4'h0, 4'h6, 3, 32'h12345678, 1, 1, 32'h12345678, 1);
        vecs[4] = mk(2'b01, 2'b01, 2'b00, 32'h10,  32'h0,   32'hA5A5A5A5, 32'h0,        4'hF, 4'h0, 0, 32'hDEADBEEF, 0, 0, 32'h0,        0);
        vecs[5] = mk(2'b01, 2'b00, 2'b01, 32'h14,  32'h0,   32'h0,        32'h0,        4'h0, 4'h0, 3, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0);
        vecs[6] = mk(2'b10, 2'b10, 2'b10, 32'h0,   32'h400, 32'h0,        32'h9ABCDEF0, 4'h0, 4'h8, 2, 32'h00000001, 1, 1, 32'h0,        1);
        vecs[7] = mk(2'b10, 2'b00, 2'b00, 32'h0,   32'h404, 32'h0,        32'h0,        4'h0, 4'hA, 0, 32'h5A5A0000, 0, 1, 32'h5A5A0000, 0);
        vecs[8] = mk(2'b11, 2'b00, 2'b11, 32'h500, 32'h600, 32'h01020304, 32'h05060708, 4'h9, 4'h6, 1, 32'h00C0FFEE, 0, 0, 32'h00C0FFEE, 0);

        repeat (2) @(negedge clk);
        chk("rst.psel_penable", {bus.PSEL, bus.PENABLE}, 2'b00);
        chk("rst.done",         bus.done, 2'b00);
        chk("rst.rsp",          {bus.rsp_err, bus.rsp_rdata}, 33'd0);
        chk("rst.addr_data",    {bus.PADDR, bus.PWDATA}, 64'd0);
        chk("rst.ctl",          {bus.PWRITE, bus.PPROT, bus.PSTRB}, 6'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle.no_req_psel", bus.PSEL, 1'b0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end
        bus.req = 2'b00;
        @(negedge clk);
        chk("idle.after_table", bus.PSEL, 1'b0);

        // Timeout: requester 0 read, PREADY never rises.
        drive_req(mk(2'b01, 2'b00, 2'b00, 32'h700, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0,
                     0, 32'h0, 0, 0, 32'h0, 1));
        bus.PRDATA = 32'hFFFFFFFF;
        @(negedge clk);
        chk("to.psel", bus.PSEL, 1'b1);
        n_en = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.PENABLE) n_en++;
            else break;
        end
        chk("to.penable_cycles", n_en, 4);
        chk("to.done",  bus.done, 2'b01);
        chk("to.err",   bus.rsp_err, 1'b1);
        chk("to.rdata", bus.rsp_rdata, 32'h0);
        chk("to.psel_low", bus.PSEL, 1'b0);
        bus.req = 2'b00;
        bus.PRDATA = '0;
        @(negedge clk);
        chk("to.idle_done", bus.done, 2'b00);

        // Reset during ACCESS after a grant to requester 0.
        bus.req = 2'b01;
        @(negedge clk);
        chk("rstmid.psel", bus.PSEL, 1'b1);
        @(negedge clk);
        chk("rstmid.penable", bus.PENABLE, 1'b1);
        bus.PREADY = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.psel_pen_drop", {bus.PSEL, bus.PENABLE}, 2'b00);
        chk("rstmid.done_drop", bus.done, 2'b00);
        chk("rstmid.paddr_zero", bus.PADDR, 32'h0);
        @(negedge clk);
        chk("rstmid.done_held", bus.done, 2'b00);
        bus.PREADY = 1'b0;
        bus.req = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid.no_done", bus.done, 2'b00);
        run_vec(mk(2'b11, 2'b11, 2'b01, 32'h800, 32'h900, 32'hAAAA0000, 32'hBBBB0000, 4'h7, 4'hE,
                   0, 32'h0, 0, 0, 32'h0, 0), "post_rst0");
        run_vec(mk(2'b11, 2'b00, 2'b10, 32'h804, 32'h904, 32'h0, 32'h0, 4'h0, 4'h0,
                   1, 32'h13579BDF, 0, 1, 32'h13579BDF, 0), "post_rst1");
        bus.req = 2'b00;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_wb_arbiter.md
APB_WB_ARBITER -- requirements
Module: apb_wb_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 ADDR_W, 32, APB address width.
REQ-002 DATA_W, 32, APB data width; multiple of 8.
REQ-003 TIMEOUT, 16, ACCESS cycles with PREADY low before abort; 0 disables timeout.
Ports (name direction width meaning):
REQ-004 PCLK  in  1  single clock; reset is asynchronous, active-low (PRESETn).
REQ-005 PRESETn  in  1  asynchronous active-low reset.
REQ-006 req  in  2  per-requester transfer request; bit i = requester i.
REQ-007 req_write  in  2  per-requester direction; 1 = write.
REQ-008 req_prot  in  2  per-requester PPROT value.
REQ-009 req_addr  in  2*ADDR_W  packed addresses; slice i = requester i.
REQ-010 req_wdata  in  2*DATA_W  packed write data.
REQ-011 req_strb  in  2*DATA_W/8  packed byte strobes.
REQ-012 done  out  2  one-cycle completion pulse to the granted requester.
REQ-013 rsp_rdata  out  DATA_W  read data; valid while done is high.
REQ-014 rsp_err  out  1  error/timeout flag; valid while done is high.
REQ-015 PADDR  out  ADDR_W  APB address to the bridge.
REQ-016 PPROT  out  1  APB protection.
REQ-017 PSEL  out  1  APB select.
REQ-018 PENABLE  out  1  APB enable.
REQ-019 PWRITE  out  1  APB direction.
REQ-020 PWDATA  out  DATA_W  APB write data.
REQ-021 PSTRB  out  DATA_W/8  APB byte strobes.
REQ-022 PREADY  in  1  APB ready from the bridge.
REQ-023 PRDATA  in  DATA_W  APB read data.
REQ-024 PSLVERR  in  1  APB slave error.

Function
REQ-025 FSM states IDLE, SETUP, ACCESS, DONE; all outputs registered.
REQ-026 IDLE: if any req bit is high at a clock edge, grant one requester, latch its fields onto PADDR/PPROT/PWRITE/PWDATA/PSTRB, set PSEL=1, go to SETUP.
REQ-027 Arbitration is round-robin: a single request is always granted; when both are high, grant the requester not granted last; last_grant updates on every grant.
REQ-028 SETUP lasts exactly one cycle (PSEL=1, PENABLE=0), then ACCESS with PENABLE=1.
REQ-029 ACCESS: on an edge with PREADY=1, capture PRDATA (reads only, else 0) and PSLVERR, drop PSEL/PENABLE, go to DONE.
REQ-030 DONE lasts one cycle: done[grant]=1, rsp_rdata/rsp_err valid, then IDLE; rsp_rdata/rsp_err return to 0 in IDLE.
REQ-031 Minimum latency: req sampled at edge N -> PSEL at N+1, PENABLE at N+2, done at N+3 with zero-wait PREADY.
REQ-032 Timeout counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0; when it reaches TIMEOUT (TIMEOUT>0), abort: PSEL/PENABLE=0, rsp_err=1, rsp_rdata=0, go to DONE.
REQ-033 Counter width is clog2(TIMEOUT+1), minimum 1; counter never wraps.
REQ-034 Requesters hold req and fields stable until done; req changes after grant are ignored until DONE.
REQ-035 Arbitration occurs only in IDLE; back-to-back transfers therefore have one idle cycle between DONE and the next SETUP.
REQ-036 PADDR/PWDATA/PSTRB/PWRITE/PPROT hold their value outside a transfer.

Reset
REQ-037 PRESETn low immediately forces state IDLE, all outputs 0, timeout counter 0, last_grant=1 (requester 0 wins the first contention), including mid-transfer; no done is issued for an aborted transfer.

Verification
REQ-038 req=01, write addr 0x10 data 0xA5A5A5A5 strb 0xF, PREADY=1 -> PSEL N+1, PENABLE N+2, done=01 at N+3, rsp_err=0.
REQ-039 req=11 held across three transfers -> grant order 0,1,0; done pulses 01,10,01.
REQ-040 Read requester 1, PREADY low 3 cycles then high with PRDATA=0x12345678, PSLVERR=1 -> done=10, rsp_rdata=0x12345678, rsp_err=1.
REQ-041 TIMEOUT=4, PREADY held low -> PENABLE high exactly 4 cycles, then done with rsp_err=1, rsp_rdata=0.
REQ-042 PRESETn asserted during ACCESS -> PSEL/PENABLE/done drop immediately; after release req=11 grants requester 0 first.
